inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Upstream neighbour of the control unit in the 16-bit single-issue CPU.
- Owns the PC and fetches instructions from instruction memory over a req/ack handshake.
- Latches each fetched word into an instruction register and presents it as `inst`, with a one-cycle `inst_valid` per instruction.
- Consumes the control unit's `PCSel`/`change` decisions to compute the next PC, and freezes on HALT.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INST, 16'hD000, IR value after reset/halt. This is a BR with nzp=000: never taken, no register or memory writes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  16  fetch address; equals `pc` while `imem_req`=1.
- imem_ack  in  1  memory response valid; `imem_rdata` is sampled when `imem_req`&`imem_ack`.
- imem_rdata  in  16  fetched instruction word.
- inst  out  16  instruction register, feeds the control unit and datapath.
- inst_valid  out  1  `inst` is executing this cycle; the datapath gates all writes with it.
- pc  out  16  PC of `inst`.
- pc_sel  in  1  control unit PCSel: 1 selects the branch/jump target.
- change  in  1  control unit change: 0 means HALT.
- jmp_target  in  16  base-register value for JMP, from the register file.
- stall  in  1  datapath busy: hold the current instruction in EXEC.
- halted  out  1  core stopped.

Behaviour:
- Reset (any state, including mid-fetch) gives, next cycle:
  - state=FETCH, `pc`=RESET_PC, `inst`=NOP_INST.
  - `inst_valid`=0, `halted`=0.
  - `imem_req` asserts in the first cycle after reset.
  - An ack arriving in the reset cycle is ignored.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - Hold `req` and `addr` stable until ack; wait states are unbounded.
  - Same-cycle ack is allowed: IR<=`imem_rdata`, go to EXEC.
- EXEC:
  - `inst_valid`=1 and `imem_req`=0.
  - `pc_sel` and `change` are sampled only in EXEC with `stall`=0.
  - `stall`=1: hold state, `inst` and `pc`; `inst_valid` stays 1.
  - `change`=0: go to HALTED; `pc` unchanged.
  - Otherwise, `pc` <= `pc_sel` ? target : `pc`+1, and go to FETCH.
- Target selection:
  - `inst[15:12]`==4'hE (JMP): target = `jmp_target`.
  - Else: target = `pc` + 1 + sext(`inst[8:0]`).
- All PC arithmetic is modulo 2^16: 16'hFFFF+1 = 16'h0000, and targets wrap silently.
- HALTED:
  - `halted`=1, `inst_valid`=0, `imem_req`=0, `inst`=NOP_INST.
  - Left only via `rst`.
- `imem_ack` outside FETCH is ignored.
- Latency: 2 cycles per instruction with zero-wait memory; +1 per memory wait cycle and +1 per stall cycle.
- Outputs are registered except `imem_addr`, which is driven from the `pc` register. No combinational path from `pc_sel`/`change` to any output.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_BR=4'hD, OP_JMP=4'hE, OP_HALT=4'hF;
  - NOP_INST;
  - fetch state enum {FETCH, EXEC, HALTED}, 2 bits.
- One natural sub-module, next_pc_calc (combinational): inputs `pc`, `inst`, `jmp_target`, `pc_sel`; output 16-bit next PC. It is reused by the branch-trace monitor.

Test Plan:
- Zero-wait memory, mem[0..2]=ADD words, then release rst -> `imem_addr` 0x0000, 0x0001, 0x0002 in successive FETCH cycles; `inst_valid` high every second cycle; `pc` matches the address.
- `pc`=0x0010, `inst`=0xDE05, `pc_sel`=1 -> next `imem_addr`=0x0016. With `inst`=0xDFFE, `pc_sel`=1 -> 0x000F. With `pc_sel`=0 -> 0x0011.
- `inst`=0xE000, `jmp_target`=0x1234, `pc_sel`=1 -> next `imem_addr`=0x1234. `pc`=0xFFFF sequential -> next 0x0000.
- Ack delayed 3 cycles -> `imem_req`=1 and `imem_addr` stable for 4 cycles. Then `stall`=1 for 2 cycles -> `inst`/`pc` held and `inst_valid`=1 for 3 cycles; `pc_sel` toggling during stall is ignored.
- `inst`=0xF000, `change`=0 -> `halted`=1 next cycle; `imem_req`=0 and `pc` frozen for 20 cycles.
- `rst` asserted mid-fetch, with ack arriving in the reset cycle -> data dropped; `pc`=RESET_PC, `inst`=0xD000, `inst_valid`=0, and a fresh fetch from 0x0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit single-issue CPU.
//   OP_*      : opcode field values (inst[15:12]) that the fetch unit and
//               control unit care about.
//   NOP_INST  : BR with nzp=000. It is never taken and writes nothing, so it
//               is a safe value to leave in the instruction register.
//   fetchState_e : fetch unit sequencing states.
//   sextOffset9  : sign-extends a 9-bit PC-relative offset to 16 bits.
package cpu_pkg;

  localparam logic [3:0]  OP_BR    = 4'hD;
  localparam logic [3:0]  OP_JMP   = 4'hE;
  localparam logic [3:0]  OP_HALT  = 4'hF;

  localparam logic [15:0] NOP_INST = 16'hD000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } fetchState_e;

  function automatic logic [15:0] sextOffset9(input logic [8:0] off);
    return {{7{off[8]}}, off};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC computation, purely combinational. Shared by the fetch unit and
// the branch-trace monitor so both agree on where control goes next.
//   pc        in  16  PC of the executing instruction
//   inst      in  16  executing instruction word
//   jmpTarget in  16  base-register value used by JMP
//   pcSel     in   1  1 = take the branch/jump target, 0 = fall through
//   nextPc    out 16  PC of the next instruction (modulo 2^16)
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [15:0] pc,
  input  logic [15:0] inst,
  input  logic [15:0] jmpTarget,
  input  logic        pcSel,
  output logic [15:0] nextPc
);

  logic [15:0] seqPc;
  logic [15:0] branchTarget;
  logic [15:0] target;

  // Bits 11:9 hold nzp / base-register fields that do not affect the target.
  logic unusedInstBits;
  assign unusedInstBits = ^inst[11:9];

  // NOTE: every signal written in an always_comb gets a value on every path;
  // a missed assignment would infer a latch.
  always_comb begin
    seqPc        = pc + 16'd1;
    branchTarget = seqPc + sextOffset9(inst[8:0]);
    target       = (inst[15:12] == OP_JMP) ? jmpTarget : branchTarget;
    nextPc       = pcSel ? target : seqPc;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack handshake,
// holds the instruction register and applies the control unit's next-PC
// decision.
//   clk, rst     clock and synchronous active-high reset
//   imem_req     out  fetch request (registered)
//   imem_addr    out  fetch address, driven straight from the PC register
//   imem_ack     in   memory response valid, used only while fetching
//   imem_rdata   in   fetched instruction word
//   inst         out  instruction register
//   inst_valid   out  inst is executing this cycle
//   pc           out  PC of inst
//   pc_sel       in   1 = take branch/jump target
//   change       in   0 = HALT
//   jmp_target   in   JMP base-register value
//   stall        in   hold the current instruction in EXEC
//   halted       out  core stopped, leaves only via rst
module inst_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] inst,
  output logic        inst_valid,
  output logic [15:0] pc,
  input  logic        pc_sel,
  input  logic        change,
  input  logic [15:0] jmp_target,
  input  logic        stall,
  output logic        halted
);

  import cpu_pkg::*;

  fetchState_e state;
  logic [15:0] nextPc;

  next_pc_calc uNextPc (
    .pc        (pc),
    .inst      (inst),
    .jmpTarget (jmp_target),
    .pcSel     (pc_sel),
    .nextPc    (nextPc)
  );

  // The address comes from the PC register, so it is stable for the whole
  // fetch without a separate address register.
  assign imem_addr = pc;

  // All outputs except imem_addr are registered; they are updated together
  // with the state so each one is a pure function of the state it enters.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset wins over everything, including an ack in the same cycle.
      state      <= FETCH;
      pc         <= RESET_PC;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
      halted     <= 1'b0;
      imem_req   <= 1'b1;
    end else begin
      unique case (state)
        FETCH: begin
          // imem_req is always high here, so ack alone completes the fetch.
          if (imem_ack) begin
            inst       <= imem_rdata;
            state      <= EXEC;
            imem_req   <= 1'b0;
            inst_valid <= 1'b1;
          end
        end

        EXEC: begin
          // pc_sel/change only matter on the single non-stalled EXEC cycle.
          if (!stall) begin
            inst_valid <= 1'b0;
            if (!change) begin
              state  <= HALTED;
              halted <= 1'b1;
              inst   <= NOP_INST;
            end else begin
              pc       <= nextPc;
              state    <= FETCH;
              imem_req <= 1'b1;
            end
          end
        end

        HALTED: begin
          // Frozen until reset; registered outputs already hold halt values.
        end

        default: begin
          state      <= FETCH;
          inst       <= NOP_INST;
          inst_valid <= 1'b0;
          halted     <= 1'b0;
          imem_req   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit. The driver plays the control unit,
// the responder plays instruction memory, and a reference model of the
// program flow pushes the expected (pc, inst) of every executed instruction.
module tb_inst_fetch_unit;

  import cpu_pkg::*;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          NUM_INST = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] inst;
  logic        inst_valid;
  logic [15:0] pc;
  logic        pc_sel = 1'b0;
  logic        change = 1'b1;
  logic [15:0] jmp_target = 16'h0000;
  logic        stall = 1'b0;
  logic        halted;

  inst_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc_sel     (pc_sel),
    .change     (change),
    .jmp_target (jmp_target),
    .stall      (stall),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] inst;
  } expect_t;

  typedef struct {
    bit          sel;
    bit          chg;
    logic [15:0] jt;
    int          stallCycles;
  } decision_t;

  expect_t     expQ[$];
  decision_t   dirQ[$];
  logic [15:0] mem [logic [15:0]];

  int vectors     = 0;
  int miscompares = 0;
  bit abort       = 1'b0;

  logic [15:0] modelPc;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] randWord();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2, 3: w[15:12] = OP_BR;
      4, 5:       w[15:12] = OP_JMP;
      6:          w = {OP_HALT, 12'h000};
      default:    w[15:12] = 4'($urandom_range(0, 12));
    endcase
    return w;
  endfunction

  function automatic logic [15:0] memRead(input logic [15:0] a);
    if (!mem.exists(a)) mem[a] = randWord();
    return mem[a];
  endfunction

  // Program-flow reference: fall through, jump to the register value, or
  // PC-relative branch with a signed 9-bit offset, all modulo 65536.
  function automatic logic [15:0] refNextPc(input logic [15:0] curPc, input logic [15:0] w,
                                            input bit sel, input logic [15:0] jt);
    int off;
    int nxt;
    if (sel && w[15:12] == OP_JMP) return jt;
    if (sel) begin
      off = int'(w[8:0]);
      if (off >= 256) off = off - 512;
    end else begin
      off = 0;
    end
    nxt = int'(curPc) + 1 + off;
    nxt = ((nxt % 65536) + 65536) % 65536;
    return 16'(nxt);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomizeCtrl();
    stall      = 1'($urandom);
    pc_sel     = 1'($urandom);
    change     = 1'($urandom);
    jmp_target = 16'($urandom);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    randomizeCtrl();
    tick();
    rst = 1'b0;
    expQ.delete();
    modelPc = RESET_PC;
    expQ.push_back('{RESET_PC, memRead(RESET_PC)});
    check("rst_pc", pc, RESET_PC);
    check("rst_inst", inst, NOP_INST);
    check("rst_inst_valid", 16'(inst_valid), 16'd0);
    check("rst_halted", 16'(halted), 16'd0);
    check("rst_imem_req", 16'(imem_req), 16'd1);
  endtask

  task automatic waitExec();
    for (int i = 0; i < 40; i++) begin
      randomizeCtrl();
      tick();
      if (inst_valid) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL exec_timeout: inst_valid never rose, expected pc %h", modelPc);
    abort = 1'b1;
  endtask

  // Monitor plus memory responder, both on the falling edge so the monitor
  // sees the ack value that was presented during the previous cycle.
  logic        prevValid = 1'b0;
  logic        prevReq   = 1'b0;
  logic        prevAck   = 1'b0;
  logic        prevRst   = 1'b1;
  logic [15:0] prevAddr  = 16'h0000;
  int          waitLeft  = 0;
  expect_t     mon;

  always @(negedge clk) begin
    if (!rst) begin
      if (inst_valid && !prevValid) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL exec_unexpected: pc %h inst %h with no expected instruction", pc, inst);
        end else begin
          mon = expQ.pop_front();
          check("exec_pc", pc, mon.pc);
          check("exec_inst", inst, mon.inst);
        end
      end
      if (imem_req) check("fetch_addr_is_pc", imem_addr, pc);
      if (imem_req && prevReq && !prevAck && !prevRst)
        check("fetch_addr_stable", imem_addr, prevAddr);
    end
    prevValid = inst_valid;
    prevReq   = imem_req;
    prevAddr  = imem_addr;
    prevRst   = rst;

    if (rst) begin
      imem_ack   = 1'b1;
      imem_rdata = 16'hBEEF;
      waitLeft   = $urandom_range(0, 3);
    end else if (imem_req) begin
      if (waitLeft == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = memRead(imem_addr);
        waitLeft   = $urandom_range(0, 3);
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        waitLeft--;
      end
    end else begin
      imem_ack   = 1'($urandom);
      imem_rdata = 16'($urandom);
    end
    prevAck = imem_ack;
  end

  initial begin
    decision_t   d;
    logic [15:0] curInst;
    logic [15:0] nxt;

    mem[16'h0000] = 16'h1001;
    mem[16'h0001] = 16'h1042;
    mem[16'h0002] = 16'h1283;
    mem[16'h0003] = 16'hE000;
    mem[16'h0004] = 16'hF000;
    mem[16'h0010] = 16'hDE05;
    mem[16'h0016] = 16'hDFFE;
    mem[16'h0015] = 16'hE000;
    mem[16'hFFFF] = 16'h1001;

    dirQ.push_back('{1'b0, 1'b1, 16'h0000, 0});
    dirQ.push_back('{1'b0, 1'b1, 16'h0000, 0});
    dirQ.push_back('{1'b0, 1'b1, 16'h0000, 0});
    dirQ.push_back('{1'b1, 1'b1, 16'h0010, 0});
    dirQ.push_back('{1'b1, 1'b1, 16'h5555, 0});
    dirQ.push_back('{1'b1, 1'b1, 16'h5555, 0});
    dirQ.push_back('{1'b1, 1'b1, 16'hFFFF, 0});
    dirQ.push_back('{1'b0, 1'b1, 16'h0000, 0});
    dirQ.push_back('{1'b0, 1'b1, 16'h0000, 2});
    dirQ.push_back('{1'b0, 1'b1, 16'h0000, 0});
    dirQ.push_back('{1'b0, 1'b1, 16'h0000, 0});
    dirQ.push_back('{1'b0, 1'b1, 16'h0099, 1});
    dirQ.push_back('{1'b0, 1'b0, 16'h0000, 0});

    repeat (3) tick();
    applyReset();

    for (int n = 0; n < NUM_INST && !abort; n++) begin
      waitExec();
      if (abort) break;

      curInst = memRead(modelPc);
      if (dirQ.size() != 0) begin
        d = dirQ.pop_front();
      end else begin
        d.sel         = 1'($urandom);
        d.chg         = (curInst[15:12] != OP_HALT);
        d.jt          = 16'($urandom);
        d.stallCycles = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      end

      for (int s = 0; s < d.stallCycles; s++) begin
        stall      = 1'b1;
        pc_sel     = 1'($urandom);
        change     = 1'($urandom);
        jmp_target = 16'($urandom);
        tick();
        check("stall_inst_valid", 16'(inst_valid), 16'd1);
        check("stall_pc", pc, modelPc);
        check("stall_inst", inst, curInst);
        check("stall_imem_req", 16'(imem_req), 16'd0);
      end

      stall      = 1'b0;
      pc_sel     = d.sel;
      change     = d.chg;
      jmp_target = d.jt;

      if (d.chg) begin
        nxt = refNextPc(modelPc, curInst, d.sel, d.jt);
        expQ.push_back('{nxt, memRead(nxt)});
        tick();
        modelPc = nxt;
        // DUT is now mid-fetch; occasionally reset it with an ack in flight.
        if ($urandom_range(0, 39) == 0) applyReset();
      end else begin
        tick();
        check("halt_halted", 16'(halted), 16'd1);
        check("halt_inst_valid", 16'(inst_valid), 16'd0);
        check("halt_imem_req", 16'(imem_req), 16'd0);
        check("halt_inst", inst, NOP_INST);
        check("halt_pc", pc, modelPc);
        for (int h = 0; h < 20; h++) begin
          randomizeCtrl();
          tick();
          check("halt_hold_halted", 16'(halted), 16'd1);
          check("halt_hold_imem_req", 16'(imem_req), 16'd0);
          check("halt_hold_pc", pc, modelPc);
        end
        applyReset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
